// File: rtl/fifo_param_if.sv
// Handshake and status bundle for fifo_param: the master drives write/read requests and
// thresholds, the slave (the FIFO) returns read data, occupancy and flags.
interface fifo_param_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 3
);

  logic [DATA_WIDTH-1:0] FIFO_data_in;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic [DATA_WIDTH-1:0] FIFO_data_out;
  logic                  data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output FIFO_data_in, push, pop, umbral_alto, umbral_bajo,
    input  FIFO_data_out, data_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fifo_error, count
  );

  modport slave (
    input  FIFO_data_in, push, pop, umbral_alto, umbral_bajo,
    output FIFO_data_out, data_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fifo_error, count
  );

endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO of 2**ADDR_WIDTH words with registered read port, programmable
// almost-full/almost-empty thresholds and a sticky overflow/underflow error flag.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input logic         clk,
  input logic         reset_L,
  fifo_param_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_error;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_full  = (r_count == DepthCnt);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same edge, so push at full is accepted when paired with pop.
  assign w_push_ok = bus.push && (!w_full || bus.pop);
  assign w_pop_ok  = bus.pop && !w_empty;

  // Storage is deliberately not reset; stale words become unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (reset_L && w_push_ok) begin
      r_mem[r_wr_ptr] <= bus.FIFO_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_data_valid <= w_pop_ok;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if ((bus.push && !w_push_ok) || (bus.pop && !w_pop_ok)) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.FIFO_data_out = r_data_out;
  assign bus.data_valid    = r_data_valid;
  assign bus.fifo_full     = w_full;
  assign bus.fifo_empty    = w_empty;
  assign bus.almost_full   = (r_count >= bus.umbral_alto);
  assign bus.almost_empty  = (r_count <= bus.umbral_bajo);
  assign bus.fifo_error    = r_error;
  assign bus.count         = r_count;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (DEPTH=4): table of per-cycle vectors with hand-computed
// results, followed by wrap-around streaming and threshold sequences.
module tb_fifo_param;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 2;

  logic clk;
  logic reset_L;

  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [AW:0]   cnt;
    logic [DW-1:0] dout;
    logic          vld;
    logic          err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic r, logic pu, logic po, logic [DW-1:0] d,
                              logic [AW:0] c, logic [DW-1:0] o, logic v, logic e);
    vec_t t;
    t.rst_n = r; t.push = pu; t.pop = po; t.din = d;
    t.cnt = c; t.dout = o; t.vld = v; t.err = e;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs change right after the previous check, well away from the rising edge.
  task automatic step(logic r, logic pu, logic po, logic [DW-1:0] d);
    reset_L          = r;
    bus.push         = pu;
    bus.pop          = po;
    bus.FIFO_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(int idx, logic [AW:0] c);
    chk("count", idx, 32'(bus.count), 32'(c));
    chk("full", idx, 32'(bus.fifo_full), 32'(c == 3'd4));
    chk("empty", idx, 32'(bus.fifo_empty), 32'(c == 3'd0));
    chk("almost_full", idx, 32'(bus.almost_full), 32'(c >= 3'd3));
    chk("almost_empty", idx, 32'(bus.almost_empty), 32'(c <= 3'd1));
  endtask

  initial begin
    reset_L          = 1'b0;
    bus.push         = 1'b0;
    bus.pop          = 1'b0;
    bus.FIFO_data_in = '0;
    bus.umbral_alto  = 3'd3;
    bus.umbral_bajo  = 3'd1;

    //            rst push pop din      cnt dout     vld err
    vecs.push_back(mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 0)); // reset
    vecs.push_back(mk(1, 1, 0, 12'h001, 1, 12'h000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 12'h002, 2, 12'h000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 12'h003, 3, 12'h000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 12'h004, 4, 12'h000, 0, 0)); // full
    vecs.push_back(mk(1, 1, 0, 12'hABC, 4, 12'h000, 0, 1)); // overflow dropped
    vecs.push_back(mk(1, 0, 1, 12'h000, 3, 12'h001, 1, 1));
    vecs.push_back(mk(1, 0, 1, 12'h000, 2, 12'h002, 1, 1));
    vecs.push_back(mk(1, 0, 1, 12'h000, 1, 12'h003, 1, 1));
    vecs.push_back(mk(1, 0, 1, 12'h000, 0, 12'h004, 1, 1)); // empty
    vecs.push_back(mk(1, 0, 1, 12'h000, 0, 12'h004, 0, 1)); // underflow
    vecs.push_back(mk(1, 1, 1, 12'h00A, 1, 12'h004, 0, 1)); // push+pop at empty
    vecs.push_back(mk(1, 0, 1, 12'h000, 0, 12'h00A, 1, 1));
    vecs.push_back(mk(1, 1, 0, 12'h011, 1, 12'h00A, 0, 1));
    vecs.push_back(mk(1, 1, 0, 12'h012, 2, 12'h00A, 0, 1));
    vecs.push_back(mk(1, 1, 0, 12'h013, 3, 12'h00A, 0, 1));
    vecs.push_back(mk(1, 1, 0, 12'h014, 4, 12'h00A, 0, 1));
    vecs.push_back(mk(1, 1, 1, 12'h005, 4, 12'h011, 1, 1)); // push+pop at full
    vecs.push_back(mk(1, 0, 1, 12'h000, 3, 12'h012, 1, 1));
    vecs.push_back(mk(0, 1, 0, 12'h555, 0, 12'h000, 0, 0)); // reset beats push
    vecs.push_back(mk(1, 1, 0, 12'h7FF, 1, 12'h000, 0, 0));
    vecs.push_back(mk(1, 0, 1, 12'h000, 0, 12'h7FF, 1, 0));
    vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h7FF, 0, 0)); // output holds

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].push, vecs[i].pop, vecs[i].din);
      chk_flags(i, vecs[i].cnt);
      chk("data_out", i, 32'(bus.FIFO_data_out), 32'(vecs[i].dout));
      chk("data_valid", i, 32'(bus.data_valid), 32'(vecs[i].vld));
      chk("error", i, 32'(bus.fifo_error), 32'(vecs[i].err));
    end

    // Stream at occupancy 2 so both pointers wrap several times.
    step(1, 1, 0, 12'h100);
    step(1, 1, 0, 12'h101);
    chk_flags(100, 3'd2);
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 1, 12'(12'h102 + k));
      chk("wrap_data", 200 + k, 32'(bus.FIFO_data_out), 32'(12'h100 + k));
      chk("wrap_valid", 200 + k, 32'(bus.data_valid), 32'd1);
      chk("wrap_count", 200 + k, 32'(bus.count), 32'd2);
    end
    chk("wrap_error", 210, 32'(bus.fifo_error), 32'd0);

    // Out-of-range thresholds only move the almost flags.
    bus.umbral_alto = 3'd7;
    bus.umbral_bajo = 3'd5;
    #1;
    chk("thr_almost_full", 300, 32'(bus.almost_full), 32'd0);
    chk("thr_almost_empty", 300, 32'(bus.almost_empty), 32'd1);
    step(1, 0, 1, 12'h000);
    chk("thr_data", 301, 32'(bus.FIFO_data_out), 32'h10A);
    step(1, 0, 1, 12'h000);
    chk("thr_data", 302, 32'(bus.FIFO_data_out), 32'h10B);
    chk("thr_count", 302, 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
